// File: rtl/conditional_check.sv
// Branch/compare condition evaluator: turns an op2 condition code and an ALU
// difference into a 1-bit flag, with a combinational copy and a registered copy.
module conditional_check #(
  parameter int DBITS        = 32,
  parameter int OP_BIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [OP_BIT_WIDTH-1:0] op2,
  input  logic [DBITS-1:0]        value,
  input  logic                    in_valid,
  output logic                    cond,
  output logic                    cond_q,
  output logic                    out_valid
);

  logic zero;
  logic neg;
  logic base;

  // The sign bit is trusted as-is; upstream subtraction overflow is not corrected.
  assign zero = (value == '0);
  assign neg  = value[DBITS-1];

  // Zero-compare codes share logic with the two-operand forms since value = a - 0.
  always_comb begin
    base = 1'b0;
    unique case (op2[2:0])
      3'b000:  base = 1'b0;
      3'b001:  base = zero;
      3'b010:  base = neg;
      3'b011:  base = neg | zero;
      3'b100:  base = 1'b0;
      3'b101:  base = zero;
      3'b110:  base = neg;
      3'b111:  base = neg | zero;
      default: base = 1'b0;
    endcase
  end

  assign cond = base ^ op2[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        cond_q <= cond;
      end
    end
  end

endmodule

// File: tb/tb_conditional_check.sv
// Bench for conditional_check: table of {op2, value, expected} vectors checked on
// the combinational flag and through a scoreboard on the registered path.
module tb_conditional_check;

  localparam int DBITS = 32;
  localparam int OPW   = 4;

  logic             clk;
  logic             reset_n;
  logic [OPW-1:0]   op2;
  logic [DBITS-1:0] value;
  logic             in_valid;
  logic             cond;
  logic             cond_q;
  logic             out_valid;

  conditional_check #(.DBITS(DBITS), .OP_BIT_WIDTH(OPW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op2       (op2),
    .value     (value),
    .in_valid  (in_valid),
    .cond      (cond),
    .cond_q    (cond_q),
    .out_valid (out_valid)
  );

  typedef struct {
    logic [OPW-1:0]   op2;
    logic [DBITS-1:0] value;
    logic             exp;
  } vec_t;

  vec_t vecs[$];
  logic sb_q[$];
  bit   sb_en;
  int   compared;
  int   mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Expected pattern bits: [2] for value = -1, [1] for 0, [0] for +1.
  task automatic add_row(input logic [OPW-1:0] code, input logic [2:0] pat);
    vecs.push_back('{op2: code, value: 32'hFFFF_FFFF, exp: pat[2]});
    vecs.push_back('{op2: code, value: 32'h0000_0000, exp: pat[1]});
    vecs.push_back('{op2: code, value: 32'h0000_0001, exp: pat[0]});
  endtask

  task automatic apply_stimulus(input logic [OPW-1:0] o, input logic [DBITS-1:0] v,
                                input logic iv);
    op2      = o;
    value    = v;
    in_valid = iv;
  endtask

  // Scoreboard consumer: every registered output with out_valid pops one expectation.
  always @(posedge clk) begin
    #1;
    if (sb_en && out_valid) begin
      if (sb_q.size() == 0) begin
        check_output("sb_unexpected_out_valid", out_valid, 1'b0);
      end else begin
        check_output("sb_cond_q", cond_q, sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    sb_en      = 1'b0;

    add_row(4'b0000, 3'b000);
    add_row(4'b0001, 3'b010);
    add_row(4'b0010, 3'b100);
    add_row(4'b0011, 3'b110);
    add_row(4'b0100, 3'b000);
    add_row(4'b0101, 3'b010);
    add_row(4'b0110, 3'b100);
    add_row(4'b0111, 3'b110);
    add_row(4'b1000, 3'b111);
    add_row(4'b1001, 3'b101);
    add_row(4'b1010, 3'b011);
    add_row(4'b1011, 3'b001);
    add_row(4'b1100, 3'b111);
    add_row(4'b1101, 3'b101);
    add_row(4'b1110, 3'b011);
    add_row(4'b1111, 3'b001);
    vecs.push_back('{op2: 4'b0010, value: 32'h8000_0000, exp: 1'b1});
    vecs.push_back('{op2: 4'b1011, value: 32'h8000_0000, exp: 1'b0});
    vecs.push_back('{op2: 4'b0001, value: 32'h8000_0000, exp: 1'b0});
    vecs.push_back('{op2: 4'b1011, value: 32'h7FFF_FFFF, exp: 1'b1});
    vecs.push_back('{op2: 4'b0011, value: 32'h7FFF_FFFF, exp: 1'b0});

    apply_stimulus(4'b1000, 32'h0, 1'b1);
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check_output("reset_cond_q", cond_q, 1'b0);
    check_output("reset_out_valid", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    check_output("reset_hold_cond_q", cond_q, 1'b0);
    check_output("reset_hold_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b1;

    sb_en = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      apply_stimulus(vecs[i].op2, vecs[i].value, 1'b1);
      #1;
      check_output($sformatf("comb_%0d_op%b_v%h", i, vecs[i].op2, vecs[i].value),
                   cond, vecs[i].exp);
      sb_q.push_back(vecs[i].exp);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    sb_en = 1'b0;
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL sb_drain: got %0d left expected 0", sb_q.size());
    end

    // Hold behaviour: capture EQ on zero, then ignore a non-zero value without in_valid.
    @(negedge clk);
    apply_stimulus(4'b1000, 32'h0, 1'b1);
    @(negedge clk);
    apply_stimulus(4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    check_output("pre_pulse_cond_q", cond_q, 1'b0);
    apply_stimulus(4'b0001, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check_output("pulse_cond_q", cond_q, 1'b1);
    check_output("pulse_out_valid", out_valid, 1'b1);
    @(negedge clk);
    apply_stimulus(4'b0001, 32'd5, 1'b0);
    @(posedge clk);
    #1;
    check_output("hold_cond_q", cond_q, 1'b1);
    check_output("hold_out_valid", out_valid, 1'b0);

    // Asynchronous reset mid-cycle, held across edges, then released.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_cond_q", cond_q, 1'b0);
    check_output("async_out_valid", out_valid, 1'b0);
    apply_stimulus(4'b0001, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_low_cond_q", cond_q, 1'b0);
    check_output("rst_low_out_valid", out_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("release_cond_q", cond_q, 1'b1);
    check_output("release_out_valid", out_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conditional_check.md
Name: conditional_check

Overview:
- Evaluates a branch/compare condition code (op2) against a signed DBITS-bit operand and returns a 1-bit condition flag.
- The operand is the difference already produced by the ALU (a - b, or a - 0 for the zero-compare forms).
- Sits between the ALU result and the CMP/CMPI writeback and Bcond branch-taken logic.
- Provides a combinational flag for same-cycle use and a registered copy for the pipeline.

Parameters:
- DBITS, 32, operand width in bits (two's complement).
- OP_BIT_WIDTH, 4, width of the op2 condition code.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op2  input  OP_BIT_WIDTH  condition code.
- value  input  DBITS  signed operand, interpreted as a two's-complement difference.
- in_valid  input  1  qualifies op2/value for the registered stage.
- cond  output  1  combinational condition result.
- cond_q  output  1  registered condition result.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Derived flags, computed from value only:
  - zero = (value == 0).
  - neg = value[DBITS-1].
- Base condition from op2[2:0]:
  - 000 F = 0
  - 001 EQ = zero
  - 010 LT = neg
  - 011 LTE = neg | zero
  - 100 (reserved) = 0
  - 101 EQZ = zero
  - 110 LTZ = neg
  - 111 LTEZ = neg | zero
- op2[3] inverts the base condition: cond = base ^ op2[3].
- Resulting codes:
  - 1000 T = 1
  - 1001 NE
  - 1010 GTE
  - 1011 GT = ~(neg | zero)
  - 1101 NEZ
  - 1110 GTEZ
  - 1111 GTZ
  - 1100 (reserved) = 1
- The zero-compare forms (EQZ/LTZ/LTEZ and their inverses) give results identical to the two-operand forms; the caller supplies value = a - 0.
- cond is purely combinational from op2 and value, with no dependence on clk or reset_n.
- Registered stage:
  - On each rising clk edge: cond_q <= cond when in_valid = 1, else cond_q holds; out_valid <= in_valid.
  - Latency is 1 cycle from in_valid to out_valid/cond_q.
- Reset: reset_n low immediately (asynchronously) forces cond_q = 0 and out_valid = 0, overriding any edge. Outputs stay at 0 while reset_n is low. First capture happens on the first rising edge after reset_n goes high.
- Sign boundaries:
  - value = most-negative (0x80000000 at DBITS=32) gives neg = 1, zero = 0.
  - value = 0x7FFFFFFF gives neg = 0, zero = 0.
  - Overflow of the upstream subtraction is not corrected here; the sign bit of value is authoritative.
- No X propagation on defined inputs: every one of the 16 op2 codes produces a defined 0 or 1.

Test Plan:
- Vary op2 over F, T, EQ, NE with value = -1 / 0 / 1:
  - F -> 0/0/0
  - T -> 1/1/1
  - EQ -> 0/1/0
  - NE -> 1/0/1
- Vary op2 over LT, GTE, LTE, GT with value = -1 / 0 / 1:
  - LT -> 1/0/0
  - GTE -> 0/1/1
  - LTE -> 1/1/0
  - GT -> 0/0/1
- Zero forms EQZ, LTZ, LTEZ, NEZ, GTEZ, GTZ with value = -1 / 0 / 1: each matches its two-operand counterpart exactly. Reserved code 0100 -> 0 for all values; 1100 -> 1 for all values.
- Extremes:
  - value = 0x80000000: LT = 1, GT = 0, EQ = 0.
  - value = 0x7FFFFFFF: GT = 1, LTE = 0.
- Registered path with op2 = EQ and value = 0:
  - Pulse in_valid for one cycle: cond_q = 1 and out_valid = 1 on the next edge.
  - Then in_valid = 0 with value = 5: cond_q holds 1 and out_valid drops to 0.
- Async reset:
  - With cond_q = 1, drop reset_n between edges: cond_q and out_valid go to 0 immediately.
  - They remain 0 across edges while reset_n is low.
  - After release, capture resumes on the next edge with in_valid = 1.
